// File: rtl/arb8_rr.sv
// Eight-way round-robin arbiter with zero-bubble handover and registered outputs.
// Optional owner hold limit is compiled in with `define ARB8_TIMEOUT_EN (uses HOLD_MAX).
module arb8_rr #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld
);

    // state | meaning
    // ------+-------------------------------------------
    // IDLE  | no owner, outputs zero, waiting for req
    // BUSY  | gnt_idx owns the resource until release
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    generate
        if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("arb8_rr: HOLD_MAX must be in 2..255");
        end
    endgenerate

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] cand;
    logic       win_found;
    logic [2:0] win_idx;
    logic       take_over;

    // First set bit of r searching p, p+1, ... with 3-bit wrap.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!res[3] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // The owner bit is masked so a releasing owner can never re-win in the same edge;
    // in IDLE gnt is zero and the mask is a no-op.
    always_comb begin
        cand = req & ~gnt;
        {win_found, win_idx} = rr_pick(cand, ptr);
    end

`ifdef ARB8_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
    logic [7:0] hold_cnt;

    always_comb begin
        take_over = !req[gnt_idx] || ((hold_cnt == HOLD_LIM) && (|cand));
    end
`else
    always_comb begin
        take_over = !req[gnt_idx];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            gnt     <= 8'h00;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
`ifdef ARB8_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state   <= BUSY;
                        gnt     <= 8'b1 << win_idx;
                        gnt_idx <= win_idx;
                        gnt_vld <= 1'b1;
                        ptr     <= win_idx + 3'd1;
`ifdef ARB8_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                BUSY: begin
                    if (take_over) begin
                        if (win_found) begin
                            gnt     <= 8'b1 << win_idx;
                            gnt_idx <= win_idx;
                            gnt_vld <= 1'b1;
                            ptr     <= win_idx + 3'd1;
`ifdef ARB8_TIMEOUT_EN
                            hold_cnt <= 8'd0;
`endif
                        end else begin
                            state   <= IDLE;
                            gnt     <= 8'h00;
                            gnt_idx <= 3'd0;
                            gnt_vld <= 1'b0;
                        end
                    end else begin
`ifdef ARB8_TIMEOUT_EN
                        if (hold_cnt != HOLD_LIM) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= 8'h00;
                    gnt_idx <= 3'd0;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/arb8_rr.md
ARB8_RR -- requirements
Module: arb8_rr

Interface
REQ-001 Parameter HOLD_MAX, default 16, maximum consecutive grant cycles per owner; range 2..255; used only when ARB8_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 req  input  8  level request per requester; bit i = requester i.
REQ-005 gnt  output  8  one-hot grant; all-zero when no owner.
REQ-006 gnt_idx  output  3  binary index of current owner; 0 when no owner.
REQ-007 gnt_vld  output  1  high when an owner exists (equals OR of gnt).
REQ-008 All outputs SHALL be registered; no combinational path from req to any output.

Function
REQ-009 States: IDLE (no owner) and BUSY (owner = gnt_idx).
REQ-010 Rotating pointer ptr[2:0] SHALL mark the highest-priority index; search order is ptr, ptr+1, ... ptr+7, mod 8 (3-bit wrap, 7 -> 0).
REQ-011 IDLE: if req != 0 at edge N, the first set bit in search order SHALL own from cycle N+1 (latency 1); state -> BUSY.
REQ-012 IDLE with req == 0: state, ptr and outputs SHALL hold.
REQ-013 BUSY, req[gnt_idx] = 1: grant SHALL hold unchanged; other requests ignored (no preemption).
REQ-014 BUSY, req[gnt_idx] = 0 (release): arbitration over req with the owner bit masked SHALL occur in the same cycle; the winner owns from next cycle (zero-bubble handover); if no winner, state -> IDLE and gnt = 0 next cycle.
REQ-015 On every new grant to index k, ptr SHALL become k+1 mod 8 in the same edge.
REQ-016 A requester that releases and re-asserts in the next cycle SHALL be ranked by the updated ptr (no immediate re-win while others wait).
REQ-017 gnt SHALL equal the 3-to-8 one-hot decode of gnt_idx whenever gnt_vld = 1.
REQ-018 At most one gnt bit SHALL be high in any cycle.
REQ-019 Requests dropped before being granted SHALL be forgotten; no request storage.

Reset
REQ-020 rst_n = 0 at an edge SHALL force, at that edge: state IDLE, ptr = 0, gnt = 0, gnt_idx = 0, gnt_vld = 0, hold counter = 0.
REQ-021 Reset SHALL take priority over any arbitration or handover in the same cycle, including mid-grant.
REQ-022 First arbitration after reset deassertion SHALL favour index 0.

Configuration
REQ-023 Macro ARB8_TIMEOUT_EN: when defined, an 8-bit hold counter SHALL clear on each new grant and increment each BUSY cycle the owner holds, saturating at HOLD_MAX.
REQ-024 With ARB8_TIMEOUT_EN, when counter = HOLD_MAX and any other req bit is set, the owner SHALL lose the grant next cycle as if released (REQ-014 masking applies).
REQ-025 With ARB8_TIMEOUT_EN, when counter = HOLD_MAX and no other req is set, the grant SHALL hold and the counter stay saturated.
REQ-026 Without ARB8_TIMEOUT_EN, no counter SHALL be built; ownership ends only on release or reset; HOLD_MAX unused.

Verification
REQ-027 Reset then req = 8'b0000_0001 -> next cycle gnt = 8'h01, gnt_idx = 0, gnt_vld = 1; ptr = 1.
REQ-028 req = 8'hFF held, each owner drops its req for one cycle after 2 cycles of grant -> owners 0,1,2,...,7,0 in order, no idle cycle between grants.
REQ-029 Owner 3 active, req = 8'b0010_1000, req[3] drops at edge N -> gnt = 8'h20, gnt_idx = 5 at N+1; all requests drop -> gnt = 0, gnt_vld = 0 next cycle.
REQ-030 rst_n = 0 for one cycle while owner 6 holds with req = 8'hC0 -> outputs zero next cycle; after release of reset, grant goes to 6 (first set from ptr 0 upward).
REQ-031 ARB8_TIMEOUT_EN, HOLD_MAX = 4: req = 8'h03 held constant -> gnt alternates 0,1 every 5 cycles; req = 8'h01 alone -> gnt = 8'h01 held indefinitely.
REQ-032 All scenarios: assertions that gnt is one-hot or zero and gnt == decode(gnt_idx) when gnt_vld = 1.
